// File: rtl/exu_alu_issue_if.sv
// Bundle of the EXU issue block's handshake and ALU signals.
// master = the EXU sequencer; slave = its environment (IDU, ALU and WBU side).
interface exu_alu_issue_if;
  // IDU -> EXU
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_imm;
  // EXU <-> combinational ALU
  logic [3:0]  alu_op;
  logic [31:0] alu_num1;
  logic [31:0] alu_num2;
  logic [31:0] alu_res;
  // EXU -> WBU
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rd_data;
  logic        out_rd_wen;
  logic [31:0] out_next_pc;
  logic        out_illegal;

  modport master (
    input  in_valid, in_opcode, in_funct3, in_funct7_5, in_pc, in_rs1, in_rs2, in_imm,
    input  alu_res, out_ready,
    output in_ready, alu_op, alu_num1, alu_num2,
    output out_valid, out_rd_data, out_rd_wen, out_next_pc, out_illegal
  );

  modport slave (
    output in_valid, in_opcode, in_funct3, in_funct7_5, in_pc, in_rs1, in_rs2, in_imm,
    output alu_res, out_ready,
    input  in_ready, alu_op, alu_num1, alu_num2,
    input  out_valid, out_rd_data, out_rd_wen, out_next_pc, out_illegal
  );
endinterface

// File: rtl/exu_alu_issue.sv
// Multicycle EXU sequencer: takes one decoded instruction, drives the shared
// combinational ALU once (twice for branches) and holds the result for WBU.
module exu_alu_issue #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic             clk,
  input logic             rst,
  exu_alu_issue_if.master bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_BR_TGT, S_DONE} state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_XOR = 4'd2, ALU_OR   = 4'd3,
    ALU_AND = 4'd4, ALU_LTS = 4'd5, ALU_SLL = 4'd6, ALU_SRL  = 4'd7,
    ALU_SRA = 4'd8, ALU_LTU = 4'd9, ALU_EQ  = 4'd10
  } alu_op_e;

  state_e          state;
  logic [6:0]      opc_q;
  logic [2:0]      f3_q;
  logic            f75_q;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;
  logic            taken_q;

  logic            out_valid_q, out_rd_wen_q, out_illegal_q;
  logic [XLEN-1:0] out_rd_data_q, out_next_pc_q;

  alu_op_e         alu_op_d;
  logic [XLEN-1:0] num1_d, num2_d;
  logic            calc_illegal;
  logic [XLEN-1:0] pc_plus4;

  // Register-register / register-immediate funct3 map; alt selects SUB or SRA.
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_LTS;
      3'b011:  arith_op = ALU_LTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  // Return address and fall-through PC come from a private adder, wrapping mod 2^32.
  assign pc_plus4 = pc_q + 32'd4;

  // Unknown opcodes and branch funct3 010/011 never touch the ALU.
  always_comb begin
    case (opc_q)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: calc_illegal = 1'b0;
      OPC_BRANCH: calc_illegal = (f3_q[2:1] == 2'b01);
      default:    calc_illegal = 1'b1;
    endcase
  end

  // ALU operand/op select; idle ALU inputs rest at zero outside CALC/BR_TGT.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    alu_op_d = ALU_ADD;
    num1_d   = '0;
    num2_d   = '0;
    if (state == S_CALC && !calc_illegal) begin
      case (opc_q)
        OPC_OP:     begin alu_op_d = arith_op(f3_q, f75_q); num1_d = rs1_q; num2_d = rs2_q; end
        OPC_OP_IMM: begin
          // ADDI has no subtract form: bit 30 is just immediate there.
          alu_op_d = arith_op(f3_q, (f3_q == 3'b101) && f75_q);
          num1_d   = rs1_q;
          num2_d   = imm_q;
        end
        OPC_LUI:    begin num1_d = '0;    num2_d = imm_q; end
        OPC_AUIPC:  begin num1_d = pc_q;  num2_d = imm_q; end
        OPC_JAL:    begin num1_d = pc_q;  num2_d = imm_q; end
        OPC_JALR:   begin num1_d = rs1_q; num2_d = imm_q; end
        OPC_BRANCH: begin
          alu_op_d = !f3_q[2] ? ALU_EQ : (!f3_q[1] ? ALU_LTS : ALU_LTU);
          num1_d   = rs1_q;
          num2_d   = rs2_q;
        end
        default: ;
      endcase
    end else if (state == S_BR_TGT) begin
      num1_d = pc_q;
      num2_d = imm_q;
    end
  end

  // Sequencer FSM: latch, compute, optional branch target, hold for WBU.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state         <= S_IDLE;
      // NOTE: latched fields are reset too, so a discarded instruction leaves no trace.
      opc_q         <= '0;
      f3_q          <= '0;
      f75_q         <= 1'b0;
      pc_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      imm_q         <= '0;
      taken_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_rd_wen_q  <= 1'b0;
      out_illegal_q <= 1'b0;
      out_rd_data_q <= '0;
      out_next_pc_q <= RESET_PC;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          opc_q         <= bus.in_opcode;
          f3_q          <= bus.in_funct3;
          f75_q         <= bus.in_funct7_5;
          pc_q          <= bus.in_pc;
          rs1_q         <= bus.in_rs1;
          rs2_q         <= bus.in_rs2;
          imm_q         <= bus.in_imm;
          out_illegal_q <= 1'b0;
          state         <= S_CALC;
        end
        S_CALC: begin
          if (calc_illegal) begin
            out_illegal_q <= 1'b1;
            out_rd_wen_q  <= 1'b0;
            out_rd_data_q <= '0;
            out_next_pc_q <= pc_plus4;
            out_valid_q   <= 1'b1;
            state         <= S_DONE;
          end else if (opc_q == OPC_BRANCH) begin
            // funct3[0] inverts the sense: BNE/BGE/BGEU.
            taken_q       <= bus.alu_res[0] ^ f3_q[0];
            out_rd_wen_q  <= 1'b0;
            out_rd_data_q <= '0;
            state         <= S_BR_TGT;
          end else begin
            out_rd_wen_q <= 1'b1;
            out_valid_q  <= 1'b1;
            state        <= S_DONE;
            case (opc_q)
              OPC_JAL:  begin out_rd_data_q <= pc_plus4; out_next_pc_q <= bus.alu_res; end
              OPC_JALR: begin out_rd_data_q <= pc_plus4; out_next_pc_q <= bus.alu_res & ~32'h1; end
              default:  begin out_rd_data_q <= bus.alu_res; out_next_pc_q <= pc_plus4; end
            endcase
          end
        end
        S_BR_TGT: begin
          out_next_pc_q <= taken_q ? bus.alu_res : pc_plus4;
          out_valid_q   <= 1'b1;
          state         <= S_DONE;
        end
        S_DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == S_IDLE);
  assign bus.alu_op      = alu_op_d;
  assign bus.alu_num1    = num1_d;
  assign bus.alu_num2    = num2_d;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_rd_data = out_rd_data_q;
  assign bus.out_rd_wen  = out_rd_wen_q;
  assign bus.out_next_pc = out_next_pc_q;
  assign bus.out_illegal = out_illegal_q;

endmodule

// File: tb/tb_exu_alu_issue.sv
// Scoreboard bench for exu_alu_issue: directed instructions push expected WBU
// results; a negedge monitor compares whatever the DUT presents.
module tb_exu_alu_issue;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exu_alu_issue_if bus();

  exu_alu_issue #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference combinational ALU sitting on the DUT's ALU port.
  always_comb begin
    case (bus.alu_op)
      4'd0:    bus.alu_res = bus.alu_num1 + bus.alu_num2;
      4'd1:    bus.alu_res = bus.alu_num1 - bus.alu_num2;
      4'd2:    bus.alu_res = bus.alu_num1 ^ bus.alu_num2;
      4'd3:    bus.alu_res = bus.alu_num1 | bus.alu_num2;
      4'd4:    bus.alu_res = bus.alu_num1 & bus.alu_num2;
      4'd5:    bus.alu_res = {31'b0, $signed(bus.alu_num1) < $signed(bus.alu_num2)};
      4'd6:    bus.alu_res = bus.alu_num1 << bus.alu_num2[4:0];
      4'd7:    bus.alu_res = bus.alu_num1 >> bus.alu_num2[4:0];
      4'd8:    bus.alu_res = $unsigned($signed(bus.alu_num1) >>> bus.alu_num2[4:0]);
      4'd9:    bus.alu_res = {31'b0, bus.alu_num1 < bus.alu_num2};
      4'd10:   bus.alu_res = {31'b0, bus.alu_num1 == bus.alu_num2};
      default: bus.alu_res = 32'h0;
    endcase
  end

  typedef struct {
    string       name;
    logic [31:0] rd_data;
    logic        rd_wen;
    logic [31:0] next_pc;
    logic        illegal;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   first    = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait expired", name);
  endtask

  // Monitor: compare every cycle the DUT presents a result; pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        if (sb.size() == 0) begin
          timeout("unexpected_out_valid");
        end else begin
          check({sb[0].name, "_rd_data"}, bus.out_rd_data, sb[0].rd_data);
          check({sb[0].name, "_rd_wen"},  {31'b0, bus.out_rd_wen}, {31'b0, sb[0].rd_wen});
          check({sb[0].name, "_next_pc"}, bus.out_next_pc, sb[0].next_pc);
          check({sb[0].name, "_illegal"}, {31'b0, bus.out_illegal}, {31'b0, sb[0].illegal});
          check({sb[0].name, "_in_ready_busy"}, {31'b0, bus.in_ready}, 32'h0);
          if (first) begin
            // valid is seen by WBU at the edge after this negedge
            check({sb[0].name, "_latency"}, cyc + 1 - sb[0].acc, sb[0].lat);
            first = 1'b0;
          end
          if (bus.out_ready) begin
            void'(sb.pop_front());
            first = 1'b1;
          end
        end
      end
    end
  end

  // Offer one instruction, record its accept edge, check the CALC-cycle alu_op.
  task automatic issue(input string name, input logic [6:0] opc, input logic [2:0] f3,
                       input logic f75, input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic [3:0] e_op,
                       input bit push, input logic [31:0] e_rd, input logic e_wen,
                       input logic [31:0] e_np, input logic e_ill, input int e_lat);
    exp_t e;
    int   w;
    @(posedge clk); #1;
    bus.in_valid    = 1'b1;
    bus.in_opcode   = opc;
    bus.in_funct3   = f3;
    bus.in_funct7_5 = f75;
    bus.in_pc       = pc;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_imm      = imm;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.in_ready) begin
      timeout({name, "_accept"});
      bus.in_valid = 1'b0;
    end else begin
      e.name = name; e.rd_data = e_rd; e.rd_wen = e_wen; e.next_pc = e_np;
      e.illegal = e_ill; e.lat = e_lat; e.acc = cyc + 1;
      if (push) sb.push_back(e);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check({name, "_alu_op"}, {28'b0, bus.alu_op}, {28'b0, e_op});
    end
  endtask

  task automatic drain(input string name);
    int w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (sb.size() != 0) timeout({name, "_drain"});
  endtask

  initial begin
    int w;
    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_funct3 = '0; bus.in_funct7_5 = 1'b0;
    bus.in_pc = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_in_ready",  {31'b0, bus.in_ready},    32'h1);
    check("rst_out_valid", {31'b0, bus.out_valid},   32'h0);
    check("rst_next_pc",   bus.out_next_pc,          RST_PC);
    check("rst_rd_data",   bus.out_rd_data,          32'h0);
    check("rst_rd_wen",    {31'b0, bus.out_rd_wen},  32'h0);
    check("rst_illegal",   {31'b0, bus.out_illegal}, 32'h0);
    check("rst_alu_op",    {28'b0, bus.alu_op},      32'h0);
    check("rst_alu_num1",  bus.alu_num1,             32'h0);
    check("rst_alu_num2",  bus.alu_num2,             32'h0);

    //     name     opcode      f3     f75  pc            rs1           rs2           imm           op    push rd            wen   next_pc       ill   lat
    issue("add",    7'b0110011, 3'b000, 1'b0, 32'h40,       32'h7,        32'hFFFF_FFFE, 32'h0,        4'd0, 1, 32'h5,         1'b1, 32'h44,       1'b0, 2);
    issue("sub",    7'b0110011, 3'b000, 1'b1, 32'h44,       32'h5,        32'h7,        32'h0,        4'd1, 1, 32'hFFFF_FFFE, 1'b1, 32'h48,       1'b0, 2);
    issue("srai",   7'b0010011, 3'b101, 1'b1, 32'h50,       32'h8000_0000, 32'h0,       32'h404,      4'd8, 1, 32'hF800_0000, 1'b1, 32'h54,       1'b0, 2);
    issue("addi_f7",7'b0010011, 3'b000, 1'b1, 32'h54,       32'd10,       32'h0,        32'hFFFF_FFFF, 4'd0, 1, 32'd9,         1'b1, 32'h58,       1'b0, 2);
    issue("sltu",   7'b0110011, 3'b011, 1'b0, 32'h58,       32'h1,        32'hFFFF_FFFF, 32'h0,        4'd9, 1, 32'h1,         1'b1, 32'h5C,       1'b0, 2);
    issue("illegal",7'b0000011, 3'b010, 1'b0, 32'h400,      32'h1234,     32'h5678,     32'h10,       4'd0, 1, 32'h0,         1'b0, 32'h404,      1'b1, 2);
    issue("lui",    7'b0110111, 3'b000, 1'b0, 32'h404,      32'hDEAD_BEEF, 32'h0,       32'h1234_5000, 4'd0, 1, 32'h1234_5000, 1'b1, 32'h408,      1'b0, 2);
    issue("br_bad", 7'b1100011, 3'b010, 1'b0, 32'h500,      32'h1,        32'h1,        32'h40,       4'd0, 1, 32'h0,         1'b0, 32'h504,      1'b1, 2);
    issue("auipc",  7'b0010111, 3'b000, 1'b0, 32'h1000,     32'h0,        32'h0,        32'h2000,     4'd0, 1, 32'h3000,      1'b1, 32'h1004,     1'b0, 2);
    issue("jal",    7'b1101111, 3'b000, 1'b0, 32'h300,      32'h0,        32'h0,        32'hFFFF_FFF0, 4'd0, 1, 32'h304,       1'b1, 32'h2F0,      1'b0, 2);
    issue("jalr",   7'b1100111, 3'b000, 1'b0, 32'h200,      32'h1003,     32'h0,        32'h4,        4'd0, 1, 32'h204,       1'b1, 32'h1006,     1'b0, 2);
    issue("blt",    7'b1100011, 3'b100, 1'b0, 32'h100,      32'hFFFF_FFFF, 32'h1,       32'hFFFF_FFF8, 4'd5, 1, 32'h0,         1'b0, 32'hF8,       1'b0, 3);
    issue("bgeu",   7'b1100011, 3'b111, 1'b0, 32'h100,      32'hFFFF_FFFF, 32'h1,       32'hFFFF_FFF8, 4'd9, 1, 32'h0,         1'b0, 32'hF8,       1'b0, 3);
    issue("bge",    7'b1100011, 3'b101, 1'b0, 32'h100,      32'hFFFF_FFFF, 32'h1,       32'hFFFF_FFF8, 4'd5, 1, 32'h0,         1'b0, 32'h104,      1'b0, 3);
    issue("bne",    7'b1100011, 3'b001, 1'b0, 32'h120,      32'h5,        32'h5,        32'h20,       4'd10, 1, 32'h0,        1'b0, 32'h124,      1'b0, 3);
    issue("pc_wrap",7'b0110011, 3'b000, 1'b0, 32'hFFFF_FFFC, 32'h1,       32'h2,        32'h0,        4'd0, 1, 32'h3,         1'b1, 32'h0,        1'b0, 2);
    drain("main");

    // Backpressure: WBU stalls five cycles; monitor checks the held values each cycle.
    #1 bus.out_ready = 1'b0;
    issue("bp_add", 7'b0110011, 3'b110, 1'b0, 32'h600,      32'hF0F0_0000, 32'h0000_0F0F, 32'h0,     4'd3, 1, 32'hF0F0_0F0F, 1'b1, 32'h604,      1'b0, 2);
    w = 0;
    while (!bus.out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.out_valid) timeout("bp_valid");
    repeat (5) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain("bp");

    // Reset while the branch target is being computed drops the instruction.
    issue("rst_beq", 7'b1100011, 3'b000, 1'b0, 32'h700,     32'h9,        32'h9,        32'h40,       4'd10, 0, 32'h0,        1'b0, 32'h0,        1'b0, 3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check("rst_mid_in_ready",  {31'b0, bus.in_ready},  32'h1);
    check("rst_mid_next_pc",   bus.out_next_pc,        RST_PC);
    repeat (4) @(posedge clk);

    // Instruction after the mid-flight reset runs normally.
    issue("post_rst", 7'b0110011, 3'b001, 1'b0, 32'h800,    32'h1,        32'h1F,       32'h0,        4'd6, 1, 32'h8000_0000, 1'b1, 32'h804,      1'b0, 2);
    drain("post_rst");
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
